xava_issue_ctrl: RTL and testbench
==================================

XAVA_ISSUE_CTRL -- requirements
Module: xava_issue_ctrl

Interface
REQ-001 Parameter: DEPTH, default 4; number of issue-queue entries (power of 2, 2..8).
REQ-002 Parameter: ID_W, default 4; width of the X-IF instruction id.
REQ-003 Port: clk_i  in  1  clock; all state updates on rising edge.
REQ-004 Port: rst_i  in  1  reset; synchronous, active-high.
REQ-005 Port: issue_valid_i  in  1; issue_ready_o  out  1 -- issue handshake.
REQ-006 Port: issue_id_i  in  ID_W; issue_instr_i  in  32; issue_rs0_i  in  32; issue_rs1_i  in  32 -- issue payload.
REQ-007 Port: issue_wb_o  out  1 -- combinational writeback flag for the offered instruction.
REQ-008 Port: commit_valid_i  in  1; commit_id_i  in  ID_W; commit_kill_i  in  1 -- commit/kill strobe.
REQ-009 Port: apu_req_o  out  1; apu_gnt_i  in  1; apu_operands_o  out  3x32 (instr, rs0, rs1) -- accelerator request.
REQ-010 Port: apu_rvalid_i  in  1; apu_result_i  in  32 -- accelerator result.
REQ-011 Port: result_valid_o  out  1; result_ready_i  in  1; result_id_o  out  ID_W; result_rd_o  out  5; result_data_o  out  32; result_we_o  out  1 -- result handshake.
REQ-012 Port: busy_o  out  1 -- queue non-empty or FSM not IDLE.

Function
REQ-013 issue_wb_o SHALL be 1 iff issue_instr_i[31:26]==6'b010000; the stored entry wb flag SHALL equal this value at enqueue.
REQ-014 issue_ready_o SHALL be 1 iff the queue holds fewer than DEPTH entries, independent of issue_valid_i.
REQ-015 Enqueue on issue_valid_i && issue_ready_o; entry = {id, instr, rs0, rs1, wb, committed=0, killed=0}, written at tail.
REQ-016 Commit strobe SHALL set committed (or killed, if commit_kill_i) on the valid entry whose id matches; a commit to an id being enqueued in the same cycle SHALL apply to that new entry.
REQ-017 Commit with no matching entry SHALL be ignored; ids of outstanding entries are unique (issuer guarantee).
REQ-018 FSM states: IDLE, REQ, WAIT_RES, RESP.
REQ-019 IDLE: head valid and killed -> pop head, stay IDLE (one cycle per killed entry); head valid, committed, not killed -> REQ; otherwise stay.
REQ-020 REQ: apu_req_o=1, apu_operands_o=head {instr, rs0, rs1}, held stable until apu_gnt_i; on grant -> WAIT_RES if head wb=1, else RESP with result_data_o=0, result_we_o=0.
REQ-021 WAIT_RES: on apu_rvalid_i capture apu_result_i into the result register -> RESP; apu_rvalid_i in any other state SHALL be ignored.
REQ-022 RESP: result_valid_o=1; result_id_o=head id, result_rd_o=head instr[11:7], result_data_o/result_we_o from the result register, all held stable until result_ready_i; on handshake pop head -> IDLE.
REQ-023 Latency: issue+commit in the same cycle at cycle N into empty idle block -> apu_req_o at N+2 earliest; apu_rvalid_i at cycle M -> result_valid_o at M+1.
REQ-024 Simultaneous enqueue and pop SHALL both take effect; count unchanged; pointers wrap modulo DEPTH.
REQ-025 Kill arriving for the head while in REQ/WAIT_RES/RESP SHALL be ignored (the instruction is already dispatched).
REQ-026 apu_req_o, result_valid_o SHALL be 0 outside REQ and RESP respectively.

Reset
REQ-027 On rst_i high at a clock edge: queue emptied, pointers/count 0, FSM IDLE, result register 0; outputs after that edge: issue_ready_o=1, apu_req_o=0, result_valid_o=0, result_we_o=0, result_data_o=0, busy_o=0.
REQ-028 Reset mid-operation SHALL discard all in-flight and queued instructions with no result issued.

Verification
REQ-029 Issue id=3 instr=0x4000_2057 (wb=1) with same-cycle commit; grant next REQ cycle; apu_rvalid_i with result 0x0000_00AB -> result_valid_o, id=3, rd=0, data=0xAB, we=1; busy_o=0 after handshake.
REQ-030 Issue 4 uncommitted instrs ids 0..3 -> issue_ready_o=0 on 5th; commit id 0 -> dispatch, pop on result handshake -> issue_ready_o=1.
REQ-031 Issue ids 1,2; kill id 1, commit id 2 -> id 1 popped without apu_req_o; only id 2 dispatched and reported.
REQ-032 Non-wb instr (funct6=0x00) committed -> after grant result_valid_o with we=0, data=0, no apu_rvalid_i needed.
REQ-033 Hold result_ready_i=0 for 5 cycles in RESP -> result_valid_o and payload stable; stray apu_rvalid_i meanwhile changes nothing.
REQ-034 Assert rst_i while in WAIT_RES with 2 queued -> next cycle all outputs at reset values, later apu_rvalid_i ignored.

Source files
------------

// File: rtl/xava_issue_ctrl.sv
// X-IF issue controller: buffers offered instructions in a small in-order queue,
// dispatches committed ones to the accelerator and returns their results.
module xava_issue_ctrl #(
    parameter int DEPTH = 4,
    parameter int ID_W  = 4
) (
    input  logic            clk_i,
    input  logic            rst_i,
    input  logic            issue_valid_i,
    output logic            issue_ready_o,
    input  logic [ID_W-1:0] issue_id_i,
    input  logic [31:0]     issue_instr_i,
    input  logic [31:0]     issue_rs0_i,
    input  logic [31:0]     issue_rs1_i,
    output logic            issue_wb_o,
    input  logic            commit_valid_i,
    input  logic [ID_W-1:0] commit_id_i,
    input  logic            commit_kill_i,
    output logic            apu_req_o,
    input  logic            apu_gnt_i,
    output logic [95:0]     apu_operands_o,
    input  logic            apu_rvalid_i,
    input  logic [31:0]     apu_result_i,
    output logic            result_valid_o,
    input  logic            result_ready_i,
    output logic [ID_W-1:0] result_id_o,
    output logic [4:0]      result_rd_o,
    output logic [31:0]     result_data_o,
    output logic            result_we_o,
    output logic            busy_o
);

    localparam int PTR_W = (DEPTH > 1) ? $clog2(DEPTH) : 1;
    localparam int CNT_W = PTR_W + 1;
    localparam logic [CNT_W-1:0] DEPTH_C = CNT_W'(DEPTH);

    typedef enum logic [1:0] {S_IDLE, S_REQ, S_WAIT_RES, S_RESP} state_t;

    state_t           r_state;
    state_t           w_state_nxt;

    logic [ID_W-1:0]  r_id    [DEPTH];
    logic [31:0]      r_instr [DEPTH];
    logic [31:0]      r_rs0   [DEPTH];
    logic [31:0]      r_rs1   [DEPTH];
    logic [DEPTH-1:0] r_valid;
    logic [DEPTH-1:0] r_wb;
    logic [DEPTH-1:0] r_committed;
    logic [DEPTH-1:0] r_killed;
    logic [PTR_W-1:0] r_head;
    logic [PTR_W-1:0] r_tail;
    logic [CNT_W-1:0] r_count;
    logic [31:0]      r_res_data;
    logic             r_res_we;

    logic             w_enq;
    logic             w_pop;
    logic             w_load_grant;
    logic             w_capture;
    logic             w_commit_new;

    assign issue_wb_o    = (issue_instr_i[31:26] == 6'b010000);
    assign issue_ready_o = (r_count < DEPTH_C);
    assign w_enq         = issue_valid_i && issue_ready_o;
    assign w_commit_new  = commit_valid_i && (commit_id_i == issue_id_i);
    assign busy_o        = (r_count != '0) || (r_state != S_IDLE);

    always_comb begin
        // NOTE: every output of this block gets a default first so no path infers a latch.
        w_state_nxt    = r_state;
        w_pop          = 1'b0;
        w_load_grant   = 1'b0;
        w_capture      = 1'b0;
        apu_req_o      = 1'b0;
        result_valid_o = 1'b0;
        case (r_state)
            S_IDLE: begin
                if (r_valid[r_head] && r_killed[r_head]) begin
                    w_pop = 1'b1;
                end else if (r_valid[r_head] && r_committed[r_head]) begin
                    w_state_nxt = S_REQ;
                end
            end
            S_REQ: begin
                apu_req_o = 1'b1;
                if (apu_gnt_i) begin
                    w_load_grant = 1'b1;
                    w_state_nxt  = r_wb[r_head] ? S_WAIT_RES : S_RESP;
                end
            end
            S_WAIT_RES: begin
                if (apu_rvalid_i) begin
                    w_capture   = 1'b1;
                    w_state_nxt = S_RESP;
                end
            end
            S_RESP: begin
                result_valid_o = 1'b1;
                if (result_ready_i) begin
                    w_pop       = 1'b1;
                    w_state_nxt = S_IDLE;
                end
            end
            default: w_state_nxt = S_IDLE;
        endcase
    end

    assign apu_operands_o = apu_req_o ? {r_instr[r_head], r_rs0[r_head], r_rs1[r_head]} : '0;
    assign result_id_o    = result_valid_o ? r_id[r_head] : '0;
    assign result_rd_o    = result_valid_o ? r_instr[r_head][11:7] : '0;
    assign result_data_o  = r_res_data;
    assign result_we_o    = r_res_we;

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            r_state     <= S_IDLE;
            r_valid     <= '0;
            r_wb        <= '0;
            r_committed <= '0;
            r_killed    <= '0;
            r_head      <= '0;
            r_tail      <= '0;
            r_count     <= '0;
            r_res_data  <= '0;
            r_res_we    <= 1'b0;
        end else begin
            r_state <= w_state_nxt;
            for (int i = 0; i < DEPTH; i++) begin
                if (commit_valid_i && r_valid[i] && (r_id[i] == commit_id_i)) begin
                    if (!commit_kill_i) begin
                        r_committed[i] <= 1'b1;
                    end else if (!((PTR_W'(i) == r_head) && (r_state != S_IDLE))) begin
                        // a dispatched head can no longer be withdrawn
                        r_killed[i] <= 1'b1;
                    end
                end
            end
            if (w_pop) begin
                r_valid[r_head] <= 1'b0;
                r_head          <= r_head + PTR_W'(1);
            end
            if (w_enq) begin
                r_valid[r_tail]     <= 1'b1;
                r_wb[r_tail]        <= issue_wb_o;
                r_committed[r_tail] <= w_commit_new && !commit_kill_i;
                r_killed[r_tail]    <= w_commit_new && commit_kill_i;
                r_tail              <= r_tail + PTR_W'(1);
            end
            r_count <= r_count + CNT_W'(w_enq) - CNT_W'(w_pop);

            if (w_load_grant) begin
                r_res_data <= '0;
                r_res_we   <= r_wb[r_head];
            end else if (w_capture) begin
                r_res_data <= apu_result_i;
            end else if (w_pop) begin
                r_res_data <= '0;
                r_res_we   <= 1'b0;
            end
        end
    end

    // NOTE: payload storage is not reset; an entry is only ever read while its valid bit is set.
    always_ff @(posedge clk_i) begin
        if (w_enq) begin
            r_id[r_tail]    <= issue_id_i;
            r_instr[r_tail] <= issue_instr_i;
            r_rs0[r_tail]   <= issue_rs0_i;
            r_rs1[r_tail]   <= issue_rs1_i;
        end
    end

endmodule

// File: tb/tb_xava_issue_ctrl.sv
// Directed self-checking bench for xava_issue_ctrl: inputs change 1 ns after the
// rising edge and outputs are sampled 1 ns later, well clear of the next edge.
module tb_xava_issue_ctrl;

    logic        clk_i = 1'b0;
    logic        rst_i;
    logic        issue_valid_i;
    logic        issue_ready_o;
    logic [3:0]  issue_id_i;
    logic [31:0] issue_instr_i;
    logic [31:0] issue_rs0_i;
    logic [31:0] issue_rs1_i;
    logic        issue_wb_o;
    logic        commit_valid_i;
    logic [3:0]  commit_id_i;
    logic        commit_kill_i;
    logic        apu_req_o;
    logic        apu_gnt_i;
    logic [95:0] apu_operands_o;
    logic        apu_rvalid_i;
    logic [31:0] apu_result_i;
    logic        result_valid_o;
    logic        result_ready_i;
    logic [3:0]  result_id_o;
    logic [4:0]  result_rd_o;
    logic [31:0] result_data_o;
    logic        result_we_o;
    logic        busy_o;

    int errors = 0;
    int checks = 0;

    xava_issue_ctrl #(.DEPTH(4), .ID_W(4)) dut (
        .clk_i(clk_i), .rst_i(rst_i),
        .issue_valid_i(issue_valid_i), .issue_ready_o(issue_ready_o),
        .issue_id_i(issue_id_i), .issue_instr_i(issue_instr_i),
        .issue_rs0_i(issue_rs0_i), .issue_rs1_i(issue_rs1_i), .issue_wb_o(issue_wb_o),
        .commit_valid_i(commit_valid_i), .commit_id_i(commit_id_i), .commit_kill_i(commit_kill_i),
        .apu_req_o(apu_req_o), .apu_gnt_i(apu_gnt_i), .apu_operands_o(apu_operands_o),
        .apu_rvalid_i(apu_rvalid_i), .apu_result_i(apu_result_i),
        .result_valid_o(result_valid_o), .result_ready_i(result_ready_i),
        .result_id_o(result_id_o), .result_rd_o(result_rd_o),
        .result_data_o(result_data_o), .result_we_o(result_we_o), .busy_o(busy_o)
    );

    always #5 clk_i = ~clk_i;

    task automatic step();
        @(posedge clk_i);
        #1;
    endtask

    task automatic idle_inputs();
        issue_valid_i  = 1'b0; issue_id_i = '0; issue_instr_i = '0;
        issue_rs0_i    = '0;   issue_rs1_i = '0;
        commit_valid_i = 1'b0; commit_id_i = '0; commit_kill_i = 1'b0;
        apu_gnt_i      = 1'b0; apu_rvalid_i = 1'b0; apu_result_i = '0;
        result_ready_i = 1'b0;
    endtask

    task automatic drive_issue(input logic [3:0] id, input logic [31:0] instr, input logic commit);
        issue_valid_i  = 1'b1; issue_id_i = id; issue_instr_i = instr;
        issue_rs0_i    = {28'h1000000, id}; issue_rs1_i = {28'h2000000, id};
        commit_valid_i = commit; commit_id_i = id; commit_kill_i = 1'b0;
    endtask

    task automatic test_reset();
        idle_inputs();
        rst_i = 1'b1;
        step();
        step();
        checks++;
        if ({issue_ready_o, apu_req_o, result_valid_o, result_we_o, result_data_o, busy_o} !== {1'b1, 1'b0, 1'b0, 1'b0, 32'h0, 1'b0}) begin
            errors++;
            $display("FAIL reset_outputs got rdy=%b req=%b rv=%b we=%b data=%h busy=%b", issue_ready_o, apu_req_o, result_valid_o, result_we_o, result_data_o, busy_o);
        end
        rst_i = 1'b0;
        step();
    endtask

    task automatic test_wb_flow();
        drive_issue(4'd3, 32'h4000_2057, 1'b1);
        #1;
        checks++;
        if ({issue_wb_o, issue_ready_o} !== 2'b11) begin
            errors++; $display("FAIL wb_flag got wb=%b rdy=%b expected 1 1", issue_wb_o, issue_ready_o);
        end
        step();
        idle_inputs();
        checks++;
        if ({apu_req_o, busy_o} !== 2'b01) begin
            errors++; $display("FAIL wb_n1 got req=%b busy=%b expected 0 1", apu_req_o, busy_o);
        end
        step();
        checks++;
        if (apu_req_o !== 1'b1 || apu_operands_o !== {32'h4000_2057, 32'h1000_0003, 32'h2000_0003}) begin
            errors++; $display("FAIL wb_req got req=%b ops=%h", apu_req_o, apu_operands_o);
        end
        apu_gnt_i = 1'b1;
        step();
        apu_gnt_i = 1'b0;
        step();
        checks++;
        if ({apu_req_o, result_valid_o, busy_o} !== 3'b001) begin
            errors++; $display("FAIL wb_wait got req=%b rv=%b busy=%b expected 0 0 1", apu_req_o, result_valid_o, busy_o);
        end
        apu_rvalid_i = 1'b1; apu_result_i = 32'h0000_00AB;
        step();
        apu_rvalid_i = 1'b0; apu_result_i = '0;
        checks++;
        if ({result_valid_o, result_id_o, result_rd_o, result_data_o, result_we_o} !== {1'b1, 4'd3, 5'd0, 32'h0000_00AB, 1'b1}) begin
            errors++; $display("FAIL wb_result got rv=%b id=%0d rd=%0d data=%h we=%b", result_valid_o, result_id_o, result_rd_o, result_data_o, result_we_o);
        end
        result_ready_i = 1'b1;
        step();
        result_ready_i = 1'b0;
        checks++;
        if ({result_valid_o, busy_o} !== 2'b00) begin
            errors++; $display("FAIL wb_done got rv=%b busy=%b expected 0 0", result_valid_o, busy_o);
        end
    endtask

    task automatic test_full();
        bit saw_req;
        bit drained;
        for (int k = 0; k < 4; k++) begin
            drive_issue(4'(k), 32'(k + 5 * (k == 0)) << 7, 1'b0);
            #1;
            checks++;
            if (issue_ready_o !== 1'b1) begin
                errors++; $display("FAIL full_fill%0d got rdy=%b expected 1", k, issue_ready_o);
            end
            step();
        end
        drive_issue(4'd4, 32'h0, 1'b0);
        #1;
        checks++;
        if ({issue_ready_o, busy_o} !== 2'b01) begin
            errors++; $display("FAIL full_ready got rdy=%b busy=%b expected 0 1", issue_ready_o, busy_o);
        end
        step();
        idle_inputs();
        commit_valid_i = 1'b1; commit_id_i = 4'd0;
        step();
        idle_inputs();
        step();
        checks++;
        if (apu_req_o !== 1'b1 || apu_operands_o[95:64] !== 32'h0000_0280) begin
            errors++; $display("FAIL full_req got req=%b instr=%h expected 1 00000280", apu_req_o, apu_operands_o[95:64]);
        end
        apu_gnt_i = 1'b1;
        step();
        apu_gnt_i = 1'b0;
        checks++;
        if ({result_valid_o, result_id_o, result_rd_o, result_data_o, result_we_o, issue_ready_o} !== {1'b1, 4'd0, 5'd5, 32'h0, 1'b0, 1'b0}) begin
            errors++; $display("FAIL full_nowb_result got rv=%b id=%0d rd=%0d data=%h we=%b rdy=%b", result_valid_o, result_id_o, result_rd_o, result_data_o, result_we_o, issue_ready_o);
        end
        result_ready_i = 1'b1;
        step();
        result_ready_i = 1'b0;
        checks++;
        if ({issue_ready_o, result_valid_o} !== 2'b10) begin
            errors++; $display("FAIL full_pop got rdy=%b rv=%b expected 1 0", issue_ready_o, result_valid_o);
        end
        saw_req = 1'b0;
        for (int k = 1; k < 4; k++) begin
            commit_valid_i = 1'b1; commit_kill_i = 1'b1; commit_id_i = 4'(k);
            step();
            saw_req |= apu_req_o;
        end
        idle_inputs();
        drained = 1'b0;
        for (int c = 0; c < 10 && !drained; c++) begin
            if (!busy_o) drained = 1'b1;
            else step();
            saw_req |= apu_req_o;
        end
        checks++;
        if ({drained, saw_req} !== 2'b10) begin
            errors++; $display("FAIL full_drain got drained=%b saw_req=%b expected 1 0", drained, saw_req);
        end
    endtask

    task automatic test_kill();
        bit saw_req;
        logic [31:0] first_instr;
        drive_issue(4'd1, 32'h4000_0080, 1'b0);
        step();
        drive_issue(4'd2, 32'h0000_0100, 1'b0);
        step();
        idle_inputs();
        commit_valid_i = 1'b1; commit_kill_i = 1'b1; commit_id_i = 4'd1;
        step();
        commit_kill_i = 1'b0; commit_id_i = 4'd2;
        step();
        idle_inputs();
        saw_req = 1'b0; first_instr = '0;
        for (int c = 0; c < 8 && !saw_req; c++) begin
            if (apu_req_o) begin
                saw_req = 1'b1; first_instr = apu_operands_o[95:64];
            end else begin
                step();
            end
        end
        checks++;
        if (!saw_req || first_instr !== 32'h0000_0100) begin
            errors++; $display("FAIL kill_dispatch got saw_req=%b instr=%h expected 1 00000100", saw_req, first_instr);
        end
        apu_gnt_i = 1'b1;
        step();
        apu_gnt_i = 1'b0;
        checks++;
        if ({result_valid_o, result_id_o, result_rd_o, result_we_o} !== {1'b1, 4'd2, 5'd2, 1'b0}) begin
            errors++; $display("FAIL kill_result got rv=%b id=%0d rd=%0d we=%b", result_valid_o, result_id_o, result_rd_o, result_we_o);
        end
        result_ready_i = 1'b1;
        step();
        result_ready_i = 1'b0;
        checks++;
        if (busy_o !== 1'b0) begin
            errors++; $display("FAIL kill_done got busy=%b expected 0", busy_o);
        end
    endtask

    task automatic test_hold();
        drive_issue(4'd5, 32'h4000_0380, 1'b1);
        step();
        idle_inputs();
        step();
        commit_valid_i = 1'b1; commit_kill_i = 1'b1; commit_id_i = 4'd5;
        step();
        idle_inputs();
        checks++;
        if (apu_req_o !== 1'b1 || apu_operands_o[95:64] !== 32'h4000_0380) begin
            errors++; $display("FAIL hold_kill_ignored got req=%b instr=%h", apu_req_o, apu_operands_o[95:64]);
        end
        apu_gnt_i = 1'b1;
        step();
        apu_gnt_i = 1'b0;
        apu_rvalid_i = 1'b1; apu_result_i = 32'h1234_5678;
        step();
        apu_rvalid_i = 1'b0;
        for (int j = 0; j < 5; j++) begin
            if (j == 1) begin
                apu_rvalid_i = 1'b1; apu_result_i = 32'hDEAD_BEEF;
            end
            checks++;
            if ({result_valid_o, result_id_o, result_rd_o, result_data_o, result_we_o} !== {1'b1, 4'd5, 5'd7, 32'h1234_5678, 1'b1}) begin
                errors++; $display("FAIL hold_stable%0d got rv=%b id=%0d rd=%0d data=%h we=%b", j, result_valid_o, result_id_o, result_rd_o, result_data_o, result_we_o);
            end
            step();
            apu_rvalid_i = 1'b0;
        end
        result_ready_i = 1'b1;
        step();
        result_ready_i = 1'b0;
        checks++;
        if ({result_valid_o, busy_o} !== 2'b00) begin
            errors++; $display("FAIL hold_done got rv=%b busy=%b expected 0 0", result_valid_o, busy_o);
        end
    endtask

    task automatic test_back_to_back();
        bit saw_req;
        drive_issue(4'd0, 32'd1 << 7, 1'b1);
        step();
        idle_inputs();
        for (int k = 0; k < 6; k++) begin
            saw_req = 1'b0;
            for (int c = 0; c < 6 && !saw_req; c++) begin
                if (apu_req_o) saw_req = 1'b1;
                else step();
            end
            checks++;
            if (!saw_req || apu_operands_o[95:64] !== (32'(k + 1) << 7)) begin
                errors++; $display("FAIL b2b_req%0d got saw_req=%b instr=%h", k, saw_req, apu_operands_o[95:64]);
            end
            apu_gnt_i = 1'b1;
            step();
            apu_gnt_i = 1'b0;
            checks++;
            if ({result_valid_o, result_id_o, result_rd_o} !== {1'b1, 4'(k), 5'(k + 1)}) begin
                errors++; $display("FAIL b2b_result%0d got rv=%b id=%0d rd=%0d", k, result_valid_o, result_id_o, result_rd_o);
            end
            result_ready_i = 1'b1;
            if (k < 5) drive_issue(4'(k + 1), 32'(k + 2) << 7, 1'b1);
            step();
            idle_inputs();
        end
        checks++;
        if ({busy_o, issue_ready_o} !== 2'b01) begin
            errors++; $display("FAIL b2b_done got busy=%b rdy=%b expected 0 1", busy_o, issue_ready_o);
        end
    endtask

    task automatic test_reset_mid();
        drive_issue(4'd8, 32'h4000_0000, 1'b1);
        step();
        drive_issue(4'd9, 32'h0000_0000, 1'b0);
        step();
        drive_issue(4'd10, 32'h0000_0000, 1'b0);
        step();
        idle_inputs();
        checks++;
        if (apu_req_o !== 1'b1) begin
            errors++; $display("FAIL rstmid_req got req=%b expected 1", apu_req_o);
        end
        apu_gnt_i = 1'b1;
        step();
        apu_gnt_i = 1'b0;
        rst_i = 1'b1;
        step();
        rst_i = 1'b0;
        checks++;
        if ({issue_ready_o, apu_req_o, result_valid_o, result_we_o, result_data_o, busy_o} !== {1'b1, 1'b0, 1'b0, 1'b0, 32'h0, 1'b0}) begin
            errors++; $display("FAIL rstmid_outputs got rdy=%b req=%b rv=%b we=%b data=%h busy=%b", issue_ready_o, apu_req_o, result_valid_o, result_we_o, result_data_o, busy_o);
        end
        apu_rvalid_i = 1'b1; apu_result_i = 32'h0000_0055;
        commit_valid_i = 1'b1; commit_id_i = 4'd9;
        step();
        idle_inputs();
        step();
        checks++;
        if ({result_valid_o, apu_req_o, busy_o, result_data_o} !== {3'b000, 32'h0}) begin
            errors++; $display("FAIL rstmid_after got rv=%b req=%b busy=%b data=%h", result_valid_o, apu_req_o, busy_o, result_data_o);
        end
    endtask

    initial begin
        idle_inputs();
        rst_i = 1'b1;
        test_reset();
        test_wb_flow();
        test_full();
        test_kill();
        test_hold();
        test_back_to_back();
        test_reset_mid();
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
